// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults and counter sizing for the hazard scoreboard
package hazard_pkg;
    localparam int DEF_NUM_REGS      = 8;
    localparam int DEF_RW            = $clog2(DEF_NUM_REGS);
    localparam int DEF_NOFWD_DIST    = 2;
    localparam int DEF_LOAD_USE_DIST = 1;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one per-register hazard down-counter with load, restore and saturating decrement
module hazard_sb_entry #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          restore,
    input  logic [CW-1:0] restore_val,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] dec;

    // saturating decrement and the larger of a new write distance or the remaining one
    always_comb begin
        dec = (cnt == '0) ? '0 : cnt - 1'b1;
    end

    // restore undoes a squashed write; a load never shortens an outstanding hazard
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (restore) cnt <= restore_val;
        else if (load) cnt <= (load_val > dec) ? load_val : dec;
        else cnt <= dec;
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register RAW hazard tracking with stall, flush undo and stall counting
// Macro HAZARD_SCOREBOARD_FWD_EN: forwarding present, only load-use distances are tracked
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NOFWD_DIST    = DEF_NOFWD_DIST,
    parameter int LOAD_USE_DIST = DEF_LOAD_USE_DIST
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs,
    input  logic [$clog2(NUM_REGS)-1:0] id_rt,
    input  logic                        id_reads_rs,
    input  logic                        id_reads_rt,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic [$clog2(NUM_REGS)-1:0] id_dest,
    input  logic                        flush,
    output logic                        stall,
    output logic                        pc_write_en,
    output logic                        if_id_write_en,
    output logic [NUM_REGS-1:0]         pending,
    output logic [15:0]                 stall_count
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = cnt_width(NOFWD_DIST, LOAD_USE_DIST);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam int LD_VAL  = LOAD_USE_DIST;
    localparam int ALU_VAL = 0;
`else
    localparam int LD_VAL  = NOFWD_DIST;
    localparam int ALU_VAL = NOFWD_DIST;
`endif

    logic [CW-1:0] cnt [NUM_REGS];
    logic [CW-1:0] shadow;
    logic [CW-1:0] shadow_dec;
    logic [CW-1:0] dest_dec;
    logic [CW-1:0] load_val;
    logic [RW-1:0] last_dest;
    logic          last_valid;
    logic          issue;
    logic          restore;
    logic [15:0]   sc;

    // hazard detection reads pre-update counters; reset and flush suppress the stall at once
    always_comb begin
        stall = id_valid & ~flush & ~rst &
                ((id_reads_rs & (cnt[id_rs] != '0)) | (id_reads_rt & (cnt[id_rt] != '0)));
        issue = id_valid & id_reg_write & ~stall & ~flush;
        restore = flush & last_valid;
        load_val = id_is_load ? CW'(LD_VAL) : CW'(ALU_VAL);
        dest_dec = (cnt[id_dest] == '0) ? '0 : cnt[id_dest] - 1'b1;
        shadow_dec = (shadow == '0) ? '0 : shadow - 1'b1;
        pc_write_en = ~stall;
        if_id_write_en = ~stall;
        stall_count = rst ? '0 : sc;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        hazard_sb_entry #(.CW(CW)) u_entry (
            .clk         (clk),
            .rst         (rst),
            .load        (issue && id_dest == RW'(i)),
            .load_val    (load_val),
            .restore     (restore && last_dest == RW'(i)),
            .restore_val (shadow_dec),
            .cnt         (cnt[i])
        );
        assign pending[i] = ~rst & (cnt[i] != '0);
    end

    // remember the most recent write so a flush next cycle can undo it; count stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            last_dest <= '0;
            last_valid <= 1'b0;
            sc <= '0;
        end else begin
            last_valid <= issue;
            if (issue) begin
                last_dest <= id_dest;
                shadow <= dest_dec;
            end
            if (stall && sc != 16'hFFFF) sc <= sc + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of the hazard scoreboard, both build configurations
module tb_hazard_scoreboard;
`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       id_valid, reads_rs, reads_rt, reg_write, is_load, flush;
    logic [2:0] rs, rt, dest;
    logic       stall, pc_we, ifid_we;
    logic [7:0] pending;
    logic [15:0] sc;

    logic       b_valid, b_reads_rs, b_reads_rt, b_reg_write, b_is_load, b_flush;
    logic [2:0] b_rs, b_rt, b_dest;
    logic       b_stall, b_pc_we, b_ifid_we;
    logic [7:0] b_pending;
    logic [15:0] b_sc;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(rs), .id_rt(rt),
        .id_reads_rs(reads_rs), .id_reads_rt(reads_rt), .id_reg_write(reg_write),
        .id_is_load(is_load), .id_dest(dest), .flush(flush), .stall(stall),
        .pc_write_en(pc_we), .if_id_write_en(ifid_we), .pending(pending), .stall_count(sc)
    );

    hazard_scoreboard #(.NOFWD_DIST(255), .LOAD_USE_DIST(255)) dut_long (
        .clk(clk), .rst(rst), .id_valid(b_valid), .id_rs(b_rs), .id_rt(b_rt),
        .id_reads_rs(b_reads_rs), .id_reads_rt(b_reads_rt), .id_reg_write(b_reg_write),
        .id_is_load(b_is_load), .id_dest(b_dest), .flush(b_flush), .stall(b_stall),
        .pc_write_en(b_pc_we), .if_id_write_en(b_ifid_we), .pending(b_pending), .stall_count(b_sc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, w, l, input logic [2:0] d, input logic ur,
                         input logic [2:0] r, input logic ut, input logic [2:0] t, input logic f);
        id_valid = v; reg_write = w; is_load = l; dest = d;
        reads_rs = ur; rs = r; reads_rt = ut; rt = t; flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        b_valid = 0; b_reads_rs = 0; b_reads_rt = 0; b_reg_write = 0; b_is_load = 0;
        b_flush = 0; b_rs = 0; b_rt = 0; b_dest = 0;
        rst = 1;
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_pending", pending, 0);
        chk("rst_count", sc, 0);
        chk("rst_pc_we", pc_we, 1);
        chk("rst_ifid_we", ifid_we, 1);
        rst = 0;

        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        chk("add_no_stall", stall, 0);
        tick();
        drive(1, 1, 0, 6, 1, 3, 0, 0, 0);
        chk("raw_t1_stall", stall, FWD ? 0 : 1);
        chk("raw_t1_pc_we", pc_we, FWD ? 1 : 0);
        chk("raw_t1_pend3", pending[3], FWD ? 0 : 1);
        tick();
        chk("raw_t2_stall", stall, FWD ? 0 : 1);
        tick();
        chk("raw_t3_stall", stall, 0);
        chk("raw_count", sc, FWD ? 0 : 2);
        idle();
        tick(); tick(); tick();
        chk("raw_drain", pending, 0);

        drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 2, 0, 0, 0);
        chk("ld_t1_stall", stall, 1);
        tick();
        chk("ld_t2_stall", stall, FWD ? 0 : 1);
        tick();
        chk("ld_t3_stall", stall, 0);
        chk("ld_count", sc, FWD ? 1 : 4);
        idle();
        tick(); tick(); tick();

        drive(1, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("rs_unused_stall", stall, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("rt_used_stall", stall, 1);
        idle();
        tick(); tick(); tick();

        drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 6, 1, 5, 0, 0, 1);
        chk("flush_stall", stall, 0);
        chk("flush_ifid_we", ifid_we, 1);
        chk("flush_pend5_before", pending[5], 1);
        tick();
        idle();
        chk("flush_pend5_after", pending[5], 0);
        chk("flush_no_issue6", pending[6], 0);
        tick(); tick(); tick();

        drive(1, 1, 1, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
        chk("waw_t1_pend4", pending[4], 1);
        tick();
        idle();
        chk("waw_t2_pend4", pending[4], FWD ? 0 : 1);
        tick();
        chk("waw_t3_pend4", pending[4], FWD ? 0 : 1);
        tick();
        chk("waw_t4_pend4", pending[4], 0);
        tick(); tick();

        drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        chk("waw_flush_pend2", pending[2], 0);
        tick(); tick(); tick();

        b_valid = 1; b_reg_write = 1; b_is_load = 1; b_dest = 4; b_reads_rs = 1; b_rs = 4;
        repeat (66000) tick();
        chk("sat_count", b_sc, 16'hFFFF);
        repeat (20) tick();
        chk("sat_hold", b_sc, 16'hFFFF);
        chk("sat_pend4", b_pending[4], 1);
        rst = 1;
        #1;
        chk("rst_mid_stall", b_stall, 0);
        tick();
        rst = 0;
        #1;
        chk("rst_b_stall", b_stall, 0);
        chk("rst_b_pending", b_pending, 0);
        chk("rst_b_count", b_sc, 0);
        chk("rst_b_pc_we", b_pc_we, 1);
        chk("rst_b_ifid_we", b_ifid_we, 1);
        chk("rst_a_count", sc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 8: architectural register count; index width RW = clog2(NUM_REGS).
REQ-002 Parameter NOFWD_DIST, default 2: counter load for any write when forwarding is compiled out.
REQ-003 Parameter LOAD_USE_DIST, default 1: counter load for a load when forwarding is compiled in.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 id_valid  in  1  IF/ID holds a real instruction.
REQ-007 id_rs, id_rt  in  RW each  source register indices.
REQ-008 id_reads_rs, id_reads_rt  in  1 each  instruction actually reads that source.
REQ-009 id_reg_write, id_is_load  in  1 each  instruction writes id_dest; the write comes from data memory.
REQ-010 id_dest  in  RW  destination register index.
REQ-011 flush  in  1  squash IF/ID and ID/EX (branch mispredict).
REQ-012 stall  out  1  hold IF/ID, bubble ID/EX.
REQ-013 pc_write_en, if_id_write_en  out  1 each  both equal ~stall.
REQ-014 pending  out  NUM_REGS  bit i = counter i nonzero.
REQ-015 stall_count  out  16  saturating count of stalled cycles.

Function
REQ-016 The block SHALL hold one down-counter per register, width clog2(max(NOFWD_DIST,LOAD_USE_DIST)+1).
REQ-017 stall SHALL be combinational, same cycle: id_valid & ~flush & ((id_reads_rs & cnt[id_rs]!=0) | (id_reads_rt & cnt[id_rt]!=0)).
REQ-018 issue = id_valid & id_reg_write & ~stall & ~flush; on issue the block SHALL load cnt[id_dest] with max(load value, sat_dec(old)).
REQ-019 Every counter not being loaded or restored SHALL decrement by 1 per cycle, saturating at 0.
REQ-020 On issue the block SHALL record last_dest = id_dest, shadow = sat_dec(old cnt[id_dest]), last_valid = 1; otherwise last_valid SHALL be 0 next cycle.
REQ-021 On flush with last_valid = 1 the block SHALL set cnt[last_dest] <= sat_dec(shadow), undoing the squashed write; with last_valid = 0 flush SHALL change no counter.
REQ-022 Flush SHALL take priority over issue in the same cycle; no issue is recorded.
REQ-023 Reads of a register being issued the same cycle SHALL see the pre-update counter.
REQ-024 stall_count SHALL increment each cycle stall = 1 and hold at 16'hFFFF.
REQ-025 A register index >= NUM_REGS SHALL never be presented; behaviour is unspecified.

Reset
REQ-026 With rst = 1 at a rising edge, all counters, shadow, last_dest, last_valid and stall_count SHALL become 0.
REQ-027 During and after reset, stall, pending and stall_count SHALL read 0; pc_write_en and if_id_write_en SHALL read 1.
REQ-028 Reset mid-operation SHALL discard all pending hazards without a settling cycle.

Configuration
REQ-029 Macro HAZARD_SCOREBOARD_FWD_EN defined: load value is LOAD_USE_DIST for a load and 0 for other writes (only load-use stalls).
REQ-030 Macro undefined: load value is NOFWD_DIST for every write (stall until writeback).

Structure
REQ-031 Package hazard_pkg SHALL hold the NUM_REGS/RW defaults, NOFWD_DIST, LOAD_USE_DIST and the counter-width function.
REQ-032 Per-register counter with load/restore/decrement SHALL be sub-module hazard_sb_entry, instantiated NUM_REGS times.

Verification
REQ-033 No fwd: ADD r3 issued at T; SUB reads r3 at T+1 -> stall=1 at T+1 and T+2, 0 at T+3; stall_count=2.
REQ-034 Fwd on: LD r2 at T, ADD reads r2 at T+1 -> stall=1 one cycle only. ADD r2 at T, reader at T+1 -> stall=0.
REQ-035 Fwd on: LD r4 at T, ADD r4 (WAW) at T+1 with no reader -> cnt[4] stays nonzero through T+1, then reaches 0.
REQ-036 LD r5 at T, flush at T+1 -> cnt[5]=0 at T+2, pending[5]=0; flush with id_valid and a hazard -> stall=0.
REQ-037 Hold a hazard 70000 cycles -> stall_count=16'hFFFF and holds; rst=1 one edge -> all outputs at reset values.
REQ-038 id_reads_rs=0 with id_rs matching a pending register -> stall=0.
